// File: rtl/lut_row_streamer_pkg.sv
// rtl/lut_row_streamer_pkg.sv - shared widths, FSM encoding and credit helper for the LUT row streamer
package lut_row_streamer_pkg;

    // Default LUT geometry shared with the matrix-vector datapath.
    localparam int RAM_WIDTH_DEF     = 32;
    localparam int RAM_ADDR_BITS_DEF = 10;

    // Sequencer state encoding, fixed so the controller can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A read may only go out if the buffered words plus the word still
    // coming back from the LUT leave at least one free FIFO slot. A pop in
    // the same cycle is deliberately not credited, which keeps this path
    // independent of out_ready.
    function automatic logic credit_ok(input int count, input logic inflight, input int depth);
        return (count + int'(inflight)) < depth;
    endfunction

endpackage

// File: rtl/lut_row_streamer_if.sv
// rtl/lut_row_streamer_if.sv - command, LUT read and output stream bundle for the LUT row streamer
//
// Signals:
//   start/base_addr/length : command from the matrix-vector controller
//   busy/done              : command status
//   lut_address/lut_data   : LUT read port (data valid one cycle after address)
//   out_valid/out_ready/out_data/out_last : output stream toward the flit packer
// Modports: slave = streamer side, master = controller/LUT/sink side.
interface lut_row_streamer_if
    import lut_row_streamer_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
);
    logic                     start;
    logic [RAM_ADDR_BITS-1:0] base_addr;
    logic [RAM_ADDR_BITS:0]   length;
    logic                     busy;
    logic                     done;
    logic [RAM_ADDR_BITS-1:0] lut_address;
    logic [RAM_WIDTH-1:0]     lut_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [RAM_WIDTH-1:0]     out_data;
    logic                     out_last;

    modport slave (
        input  start, base_addr, length, lut_data, out_ready,
        output busy, done, lut_address, out_valid, out_data, out_last
    );

    modport master (
        output start, base_addr, length, lut_data, out_ready,
        input  busy, done, lut_address, out_valid, out_data, out_last
    );
endinterface

// File: rtl/lut_stream_fifo.sv
// rtl/lut_stream_fifo.sv - small synchronous FIFO buffering LUT words plus last tag
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, data_i  : write strobe and word
//   pop_i           : read strobe (head advances)
//   data_o          : head entry
//   empty_o         : no entries held
//   count_o         : number of entries held (0..DEPTH)
module lut_stream_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves that cycle.
    assign do_push = push_i && (!full || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !pop_i));

endmodule

// File: rtl/lut_row_streamer.sv
// rtl/lut_row_streamer.sv - walks a LUT address range and streams the returned words
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lut_row_streamer_if.slave (command, status, LUT read port, output stream)
module lut_row_streamer
    import lut_row_streamer_pkg::*;
#(
    parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
    parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    lut_row_streamer_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [RAM_ADDR_BITS:0] ONE = (RAM_ADDR_BITS + 1)'(1);

    state_e                   state_q;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [RAM_ADDR_BITS:0]   remaining_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic                     done_q;

    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic [RAM_WIDTH:0]       fifo_head;

    logic                     issue;
    logic                     last_issue;
    logic                     pop;
    logic                     last_pop;

    // addr_q always holds the address being presented; a read counts as
    // issued in any ISSUE cycle that has credit.
    assign issue      = (state_q == ST_ISSUE) &&
                        credit_ok(int'(fifo_count), inflight_q, FIFO_DEPTH);
    assign last_issue = issue && (remaining_q == ONE);
    assign pop        = !fifo_empty && bus.out_ready;
    assign last_pop   = pop && fifo_head[RAM_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.length != '0) begin
                            state_q     <= ST_ISSUE;
                            addr_q      <= bus.base_addr;
                            remaining_q <= bus.length;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        remaining_q <= remaining_q - ONE;
                        if (remaining_q == ONE) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            // Natural overflow gives the modulo-2^N wrap.
                            addr_q <= addr_q + RAM_ADDR_BITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    lut_stream_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  ({inflight_last_q, bus.lut_data}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.lut_address = addr_q;
    assign bus.out_valid   = !fifo_empty;
    // Unwritten FIFO storage is masked so idle outputs read as zero.
    assign bus.out_data    = fifo_empty ? '0 : fifo_head[RAM_WIDTH-1:0];
    assign bus.out_last    = !fifo_empty && fifo_head[RAM_WIDTH];

endmodule

// File: tb/tb_lut_row_streamer.sv
// tb/tb_lut_row_streamer.sv - scoreboard bench for lut_row_streamer
module tb_lut_row_streamer;
    localparam int W  = 32;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [W:0] exp_q [$];
    logic [W-1:0] lut_mem [1 << AB];

    logic         stall_q = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;

    lut_row_streamer_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

    lut_row_streamer #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered-read LUT model.
    always @(posedge clk) bus.lut_data <= lut_mem[bus.lut_address];

    task automatic chk(input string name, input logic [W:0] got, input logic [W:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n) begin
            if (stall_q) begin
                chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data[W-2:0]},
                    {1'b1, stall_last, stall_data[W-2:0]});
                chk("stall_data", {1'b0, bus.out_data}, {1'b0, stall_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {bus.out_last, bus.out_data}, e);
                end
            end
            stall_q    = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic pulse_start(input int b, input int l);
        bus.base_addr = AB'(b);
        bus.length    = (AB + 1)'(l);
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start  = 1'b0;
    endtask

    task automatic start_cmd(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back({(i == l - 1), W'(32'h100 + ((b + i) % (1 << AB)))});
        end
        pulse_start(b, l);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk("done_seen", {32'd0, seen}, 33'd1);
        chk("queue_empty", 33'(exp_q.size()), 33'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_once", {32'd0, bus.done}, 33'd0);
        end
    endtask

    initial begin
        logic [AB-1:0] held_addr;
        for (int i = 0; i < (1 << AB); i++) lut_mem[i] = W'(32'h100 + i);
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {32'd0, bus.busy}, 33'd0);
        chk("rst_done",  {32'd0, bus.done}, 33'd0);
        chk("rst_addr",  33'(bus.lut_address), 33'd0);
        chk("rst_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("rst_last",  {32'd0, bus.out_last}, 33'd0);
        chk("rst_data",  {1'b0, bus.out_data}, 33'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic: cycle-accurate timing of a 4-word command.
        start_cmd(5, 4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 4) chk("basic_addr", 33'(bus.lut_address), 33'(4 + c));
            chk("basic_valid", {32'd0, bus.out_valid}, {32'd0, (c >= 3 && c <= 6)});
            chk("basic_done",  {32'd0, bus.done}, {32'd0, (c == 7)});
            chk("basic_busy",  {32'd0, bus.busy}, {32'd0, (c <= 6)});
        end
        chk("basic_queue", 33'(exp_q.size()), 33'd0);

        // Wrap across the top of the address space.
        start_cmd(1022, 3);
        wait_done(50);

        // Backpressure with an ignored start while busy.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        start_cmd(16, 8);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 3) chk("bp_head", {bus.out_valid, bus.out_data}, {1'b1, 32'h110});
        end
        chk("bp_stall_addr", 33'(bus.lut_address), 33'd20);
        pulse_start(512, 5);
        @(negedge clk);
        chk("bp_addr_after_start", 33'(bus.lut_address), 33'd20);
        chk("bp_busy", {32'd0, bus.busy}, 33'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done(100);

        // Zero length: immediate done, nothing issued or streamed.
        held_addr = bus.lut_address;
        pulse_start(100, 0);
        @(negedge clk);
        chk("zero_done",  {32'd0, bus.done}, 33'd1);
        chk("zero_busy",  {32'd0, bus.busy}, 33'd0);
        chk("zero_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("zero_addr",  33'(bus.lut_address), 33'(held_addr));
        @(negedge clk);
        chk("zero_done_pulse", {32'd0, bus.done}, 33'd0);
        chk("zero_valid2", {32'd0, bus.out_valid}, 33'd0);

        // Full address range.
        start_cmd(0, 1024);
        wait_done(1100);

        // Reset during word 3 of 8.
        start_cmd(64, 8);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("mid_rst_busy",  {32'd0, bus.busy}, 33'd0);
        chk("mid_rst_done",  {32'd0, bus.done}, 33'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {32'd0, bus.out_valid}, 33'd0);
        start_cmd(0, 2);
        wait_done(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
